dmem_demux2: RTL and testbench
==============================

# dmem_demux2

Data-memory request demultiplexer: routes one initiator (the MEM-stage load/store port) to one of two targets (t0 = data RAM, t1 = MMIO) by address decode, then steers the matching response back. Sits between the pipeline's memory stage and the memory/peripheral fabric. It allows one outstanding transaction and uses valid/ready handshakes on every channel.

## Interface
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, data width; a multiple of 8
- T0_BASE, 32'h0000_0000, t0 window base
- T0_MASK, 32'hF000_0000, t0 window mask; hit when (addr & T0_MASK) == T0_BASE
- T1_BASE, 32'h1000_0000, t1 window base
- T1_MASK, 32'hF000_0000, t1 window mask; t1 takes priority if both windows hit
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid / req_ready  in / out  1  initiator request handshake
- req_addr, req_wdata  in  ADDR_WIDTH / DATA_WIDTH  request address and write data
- req_we  in  1  write when 1, read when 0
- req_wstrb  in  DATA_WIDTH/8  byte write enables
- rsp_valid / rsp_ready  out / in  1  initiator response handshake
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  decode error response
- tN_req_valid / tN_req_ready  out / in  1  target N request handshake (N = 0, 1)
- tN_req_addr, tN_req_we, tN_req_wdata, tN_req_wstrb  out  as initiator  forwarded request fields
- tN_rsp_valid / tN_rsp_ready  in / out  1  target N response handshake
- tN_rsp_rdata  in  DATA_WIDTH  target N read data

## Operation
- States: IDLE, WAIT0, WAIT1, ERR. Reset state is IDLE.
- IDLE: decode req_addr combinationally. Drive tN_req_valid = req_valid for the selected target only. req_ready = selected tN_req_ready.
  - Handshake to t0 (t1) -> WAIT0 (WAIT1).
  - No handshake -> stay in IDLE. Request fields must be held stable by the initiator.
- tN request fields are always a direct copy of the initiator fields. Only the valid bits are steered.
- WAITn: req_ready = 0, and both tN_req_valid = 0.
  - rsp_valid = tn_rsp_valid and rsp_rdata = tn_rsp_rdata (forced 0 if the request was a write; req_we is registered at acceptance).
  - tn_rsp_ready = rsp_ready. The non-selected target's rsp_ready = 0; its rsp_valid is ignored.
  - Response handshake -> IDLE.
- ERR: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0. On rsp_ready -> IDLE.
- rsp_err = 0 in every state except ERR.
- Unaccepted targets' rsp_ready is 0 in every state.

## Timing
- Request forwarding is combinational: 0 cycles from initiator to target.
- Response steering is combinational: 0 cycles from target to initiator.
- Minimum round trip: accept in cycle N, response at the earliest in N+1.
- A new request is accepted at the earliest in the cycle after the response handshake (one-cycle turnaround).
- While reset is high, all valid/ready outputs are 0, regardless of the inputs. rsp_rdata = 0 and rsp_err = 0.
- Reset mid-transaction: outputs drop immediately and the state returns to IDLE. Any late target response is ignored; targets share the same reset.
- Simultaneous tn_rsp_valid and stray t(other)_rsp_valid: only the selected target's response is passed through.

## Configuration
- DMEM_DEMUX2_DECERR_EN defined:
  - An address hitting neither window is accepted in IDLE (req_ready = 1) with no tN_req_valid asserted.
  - The state moves to ERR, giving an error response in cycle N+1.
- DMEM_DEMUX2_DECERR_EN undefined:
  - t0 is the default target for any address that misses t1. State ERR is not built. rsp_err is tied to 0.

## Test plan
- Write 0x0000_0040 / 0xDEADBEEF / wstrb 0xF, t0_req_ready = 1 -> t0_req_valid in the same cycle. t0_rsp_valid next cycle -> rsp_valid = 1, rsp_rdata = 0, back to IDLE.
- Read 0x1000_0004 with t1_req_ready low for 3 cycles -> req_ready = 0 for 3 cycles, accepted in cycle 4. t1_rsp_rdata = 0x0000_00A5 -> rsp_rdata = 0x0000_00A5.
- rsp_ready held low 2 cycles in WAIT1 -> rsp_valid and rsp_rdata stable, t1_rsp_ready = 0. A new req_valid is not accepted until 1 cycle after the response handshake.
- Stray t0_rsp_valid = 1 with 0x1234 during WAIT1 -> rsp_valid = 0, t0_rsp_ready = 0, state unchanged.
- reset pulsed during WAIT0 -> all valid/ready outputs 0 immediately. After release: IDLE, and a read to 0x0000_0000 completes normally.
- Read 0x8000_0000 -> with DMEM_DEMUX2_DECERR_EN: no tN_req_valid, next cycle rsp_valid = 1, rsp_err = 1, rsp_rdata = 0. Without it: forwarded to t0.

Source files
------------

// File: rtl/dmem_demux2.sv
// Routes one load/store initiator to t0 (RAM) or t1 (MMIO) by address window; optional decode-error target via DMEM_DEMUX2_DECERR_EN.
// Latency: request and response paths are combinational (0 cycles); one transaction outstanding, one-cycle turnaround.
// Backpressure: req_ready follows the selected target's ready; the response waits on rsp_ready with the target stalled.
module dmem_demux2 #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] T0_BASE    = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] T0_MASK    = 32'hF000_0000,
    parameter logic [ADDR_WIDTH-1:0] T1_BASE    = 32'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0] T1_MASK    = 32'hF000_0000
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic                    req_we,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,

    output logic                    t0_req_valid,
    input  logic                    t0_req_ready,
    output logic [ADDR_WIDTH-1:0]   t0_req_addr,
    output logic                    t0_req_we,
    output logic [DATA_WIDTH-1:0]   t0_req_wdata,
    output logic [DATA_WIDTH/8-1:0] t0_req_wstrb,
    input  logic                    t0_rsp_valid,
    output logic                    t0_rsp_ready,
    input  logic [DATA_WIDTH-1:0]   t0_rsp_rdata,

    output logic                    t1_req_valid,
    input  logic                    t1_req_ready,
    output logic [ADDR_WIDTH-1:0]   t1_req_addr,
    output logic                    t1_req_we,
    output logic [DATA_WIDTH-1:0]   t1_req_wdata,
    output logic [DATA_WIDTH/8-1:0] t1_req_wstrb,
    input  logic                    t1_rsp_valid,
    output logic                    t1_rsp_ready,
    input  logic [DATA_WIDTH-1:0]   t1_rsp_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT0,
        WAIT1
`ifdef DMEM_DEMUX2_DECERR_EN
        , ERR
`endif
    } state_t;

    state_t state_q, state_d;
    logic   we_q, we_d;

    logic t0_hit, t1_hit;

    assign t0_hit = (req_addr & T0_MASK) == T0_BASE;
    assign t1_hit = (req_addr & T1_MASK) == T1_BASE;

`ifndef DMEM_DEMUX2_DECERR_EN
    // t0 catches every t1 miss, so its own window match is not needed here.
    logic unused_t0_hit;
    assign unused_t0_hit = t0_hit;
`endif

    // Payload fields fan out unconditionally; only the valids are steered.
    assign t0_req_addr  = req_addr;
    assign t0_req_we    = req_we;
    assign t0_req_wdata = req_wdata;
    assign t0_req_wstrb = req_wstrb;
    assign t1_req_addr  = req_addr;
    assign t1_req_we    = req_we;
    assign t1_req_wdata = req_wdata;
    assign t1_req_wstrb = req_wstrb;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_rdata    = '0;
        rsp_err      = 1'b0;
        t0_req_valid = 1'b0;
        t1_req_valid = 1'b0;
        t0_rsp_ready = 1'b0;
        t1_rsp_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (t1_hit) begin
                    t1_req_valid = req_valid;
                    req_ready    = t1_req_ready;
                    if (req_valid && t1_req_ready) begin
                        state_d = WAIT1;
                        we_d    = req_we;
                    end
`ifdef DMEM_DEMUX2_DECERR_EN
                end else if (t0_hit) begin
                    t0_req_valid = req_valid;
                    req_ready    = t0_req_ready;
                    if (req_valid && t0_req_ready) begin
                        state_d = WAIT0;
                        we_d    = req_we;
                    end
                end else begin
                    // Unmapped address: absorb it here and answer with an error.
                    req_ready = 1'b1;
                    if (req_valid) begin
                        state_d = ERR;
                        we_d    = req_we;
                    end
                end
`else
                end else begin
                    t0_req_valid = req_valid;
                    req_ready    = t0_req_ready;
                    if (req_valid && t0_req_ready) begin
                        state_d = WAIT0;
                        we_d    = req_we;
                    end
                end
`endif
            end
            WAIT0: begin
                rsp_valid    = t0_rsp_valid;
                rsp_rdata    = we_q ? '0 : t0_rsp_rdata;
                t0_rsp_ready = rsp_ready;
                if (t0_rsp_valid && rsp_ready) begin
                    state_d = IDLE;
                end
            end
            WAIT1: begin
                rsp_valid    = t1_rsp_valid;
                rsp_rdata    = we_q ? '0 : t1_rsp_rdata;
                t1_rsp_ready = rsp_ready;
                if (t1_rsp_valid && rsp_ready) begin
                    state_d = IDLE;
                end
            end
`ifdef DMEM_DEMUX2_DECERR_EN
            ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are quiet for the whole reset pulse, not just after the next edge.
        if (reset) begin
            req_ready    = 1'b0;
            rsp_valid    = 1'b0;
            rsp_rdata    = '0;
            rsp_err      = 1'b0;
            t0_req_valid = 1'b0;
            t1_req_valid = 1'b0;
            t0_rsp_ready = 1'b0;
            t1_rsp_ready = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
        end
    end

endmodule

// File: tb/tb_dmem_demux2.sv
// Directed bench for dmem_demux2: inputs change on the falling edge, outputs are checked 1 ns later.
module tb_dmem_demux2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        t0_req_valid, t0_req_ready, t0_req_we, t0_rsp_valid, t0_rsp_ready;
    logic [31:0] t0_req_addr, t0_req_wdata, t0_rsp_rdata;
    logic [3:0]  t0_req_wstrb;
    logic        t1_req_valid, t1_req_ready, t1_req_we, t1_rsp_valid, t1_rsp_ready;
    logic [31:0] t1_req_addr, t1_req_wdata, t1_rsp_rdata;
    logic [3:0]  t1_req_wstrb;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    dmem_demux2 dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .t0_req_valid(t0_req_valid), .t0_req_ready(t0_req_ready), .t0_req_addr(t0_req_addr),
        .t0_req_we(t0_req_we), .t0_req_wdata(t0_req_wdata), .t0_req_wstrb(t0_req_wstrb),
        .t0_rsp_valid(t0_rsp_valid), .t0_rsp_ready(t0_rsp_ready), .t0_rsp_rdata(t0_rsp_rdata),
        .t1_req_valid(t1_req_valid), .t1_req_ready(t1_req_ready), .t1_req_addr(t1_req_addr),
        .t1_req_we(t1_req_we), .t1_req_wdata(t1_req_wdata), .t1_req_wstrb(t1_req_wstrb),
        .t1_rsp_valid(t1_rsp_valid), .t1_rsp_ready(t1_rsp_ready), .t1_rsp_rdata(t1_rsp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge (one full rising edge in between).
    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b1; req_addr = 32'h0; req_we = 1'b0; req_wdata = 32'h0; req_wstrb = 4'h0;
        rsp_ready = 1'b1;
        t0_req_ready = 1'b1; t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'h1111_1111;
        t1_req_ready = 1'b1; t1_rsp_valid = 1'b1; t1_rsp_rdata = 32'h2222_2222;

        // Reset: outputs quiet even with every input asserted.
        @(negedge clk); settle();
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_t0_req_valid", {31'b0, t0_req_valid}, 32'd0);
        chk("rst_t1_req_valid", {31'b0, t1_req_valid}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_t0_rsp_ready", {31'b0, t0_rsp_ready}, 32'd0);
        chk("rst_t1_rsp_ready", {31'b0, t1_rsp_ready}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);

        // Write to t0, same-cycle forwarding.
        step();
        reset = 1'b0; t0_rsp_valid = 1'b0; t1_rsp_valid = 1'b0; t1_req_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0000_0040; req_we = 1'b1;
        req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF;
        settle();
        chk("wr_t0_req_valid", {31'b0, t0_req_valid}, 32'd1);
        chk("wr_t1_req_valid", {31'b0, t1_req_valid}, 32'd0);
        chk("wr_req_ready", {31'b0, req_ready}, 32'd1);
        chk("wr_t0_wdata", t0_req_wdata, 32'hDEAD_BEEF);
        chk("wr_t0_wstrb", {28'b0, t0_req_wstrb}, 32'hF);
        chk("wr_t1_addr_copy", t1_req_addr, 32'h0000_0040);
        step();
        req_valid = 1'b0; t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'hFFFF_FFFF; rsp_ready = 1'b1;
        settle();
        chk("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("wr_rsp_rdata_zero", rsp_rdata, 32'd0);
        chk("wr_t0_rsp_ready", {31'b0, t0_rsp_ready}, 32'd1);
        chk("wr_wait_req_ready", {31'b0, req_ready}, 32'd0);

        // Read to t1 with the target stalling for 3 cycles.
        step();
        t0_rsp_valid = 1'b0;
        req_valid = 1'b1; req_addr = 32'h1000_0004; req_we = 1'b0; t1_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rd_stall_req_ready", {31'b0, req_ready}, 32'd0);
            chk("rd_stall_t1_valid", {31'b0, t1_req_valid}, 32'd1);
            step();
        end
        t1_req_ready = 1'b1;
        settle();
        chk("rd_accept_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rd_accept_t0_valid", {31'b0, t0_req_valid}, 32'd0);

        // WAIT1 with a stray t0 response.
        step();
        t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'h0000_1234; rsp_ready = 1'b1;
        settle();
        chk("stray_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("stray_t0_rsp_ready", {31'b0, t0_rsp_ready}, 32'd0);
        chk("wait_req_ready", {31'b0, req_ready}, 32'd0);
        chk("wait_t1_req_valid", {31'b0, t1_req_valid}, 32'd0);

        // Response held off by the initiator for 2 cycles.
        step();
        t0_rsp_valid = 1'b0; t1_rsp_valid = 1'b1; t1_rsp_rdata = 32'h0000_00A5; rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, 32'h0000_00A5);
            chk("hold_t1_rsp_ready", {31'b0, t1_rsp_ready}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        settle();
        chk("rd_rsp_rdata", rsp_rdata, 32'h0000_00A5);
        chk("rd_t1_rsp_ready", {31'b0, t1_rsp_ready}, 32'd1);
        chk("turn_no_accept", {31'b0, req_ready}, 32'd0);
        step();
        t1_rsp_valid = 1'b0;
        settle();
        chk("turn_accept", {31'b0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0; t1_rsp_valid = 1'b1; t1_rsp_rdata = 32'h0000_0077;
        settle();
        chk("rd2_rsp_rdata", rsp_rdata, 32'h0000_0077);

        // Reset pulsed during WAIT0.
        step();
        t1_rsp_valid = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0000_0000; req_we = 1'b0; t0_req_ready = 1'b1;
        settle();
        chk("pre_rst_t0_req_valid", {31'b0, t0_req_valid}, 32'd1);
        step();
        t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'h0000_0055; rsp_ready = 1'b0; reset = 1'b1;
        settle();
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("midrst_t0_req_valid", {31'b0, t0_req_valid}, 32'd0);
        chk("midrst_t0_rsp_ready", {31'b0, t0_rsp_ready}, 32'd0);
        step();
        reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        settle();
        chk("postrst_late_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("postrst_late_t0_rsp_ready", {31'b0, t0_rsp_ready}, 32'd0);
        step();
        t0_rsp_valid = 1'b0; req_valid = 1'b1;
        settle();
        chk("postrst_req_ready", {31'b0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0; t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'hCAFE_0001;
        settle();
        chk("postrst_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("postrst_rsp_rdata", rsp_rdata, 32'hCAFE_0001);

        // Address outside both windows.
        step();
        t0_rsp_valid = 1'b0;
        req_valid = 1'b1; req_addr = 32'h8000_0000; req_we = 1'b0;
        t0_req_ready = 1'b1; t1_req_ready = 1'b0;
        settle();
        chk("miss_req_ready", {31'b0, req_ready}, 32'd1);
        chk("miss_t1_req_valid", {31'b0, t1_req_valid}, 32'd0);
`ifdef DMEM_DEMUX2_DECERR_EN
        chk("miss_t0_req_valid", {31'b0, t0_req_valid}, 32'd0);
        step();
        req_valid = 1'b0; t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'h0000_0099; rsp_ready = 1'b0;
        settle();
        chk("err_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("err_rsp_err", {31'b0, rsp_err}, 32'd1);
        chk("err_rsp_rdata", rsp_rdata, 32'd0);
        chk("err_t0_rsp_ready", {31'b0, t0_rsp_ready}, 32'd0);
        step();
        rsp_ready = 1'b1;
        settle();
        chk("err_hold_rsp_err", {31'b0, rsp_err}, 32'd1);
        step();
        t0_rsp_valid = 1'b0;
        settle();
        chk("err_done_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("err_done_rsp_err", {31'b0, rsp_err}, 32'd0);
`else
        chk("miss_t0_req_valid", {31'b0, t0_req_valid}, 32'd1);
        step();
        req_valid = 1'b0; t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'h0000_0099; rsp_ready = 1'b1;
        settle();
        chk("miss_rsp_rdata", rsp_rdata, 32'h0000_0099);
        chk("miss_rsp_err", {31'b0, rsp_err}, 32'd0);
        step();
        t0_rsp_valid = 1'b0;
        settle();
        chk("miss_done_rsp_valid", {31'b0, rsp_valid}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
